or7_equiv_checker: RTL and testbench



---
 rtl/or7_chk_pkg.sv | 26 ++
 rtl/or7_vec_gen.sv | 77 +++++++
 rtl/or7_equiv_checker.sv | 125 ++++++++++++
 tb/tb_or7_equiv_checker.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or7_chk_pkg.sv
// ---------------------------------------------------------------------------
// or7_chk_pkg
// Shared definitions for the OR7 equivalence checker: default widths, the
// checker state type, the LFSR tap positions and the run lengths of the two
// stimulus modes.
// ---------------------------------------------------------------------------
package or7_chk_pkg;

  localparam int unsigned N_IN_DEF  = 7;
  localparam int unsigned N_OUT_DEF = 2;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // x^7 + x^6 + 1: feedback is vec[6] ^ vec[5], shifted in at bit 0.
  localparam int unsigned LFSR_TAP_HI = 6;
  localparam int unsigned LFSR_TAP_LO = 5;

  localparam int unsigned EXH_VECTORS  = 128;
  localparam int unsigned LFSR_VECTORS = 127;

endpackage

// File: rtl/or7_vec_gen.sv
// ---------------------------------------------------------------------------
// or7_vec_gen
// Stimulus vector register for the OR7 checker. Loads the start vector
// (0 for exhaustive mode, the seed for LFSR mode), advances it one step per
// compared vector and flags the last vector of the run.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   load    in   begin a run: latch mode, load start vector, clear index
//   clear   in   return vector and index to 0 (end of run / abort)
//   advance in   step to the next vector
//   mode    in   0 = exhaustive count, 1 = LFSR (sampled on load only)
//   seed    in   LFSR start value; 0 is replaced by 1
//   vec     out  current vector driving both DUT variants
//   last    out  current vector is the final one of the run
// ---------------------------------------------------------------------------
module or7_vec_gen
  import or7_chk_pkg::*;
#(
  parameter int unsigned N_IN = N_IN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic            advance,
  input  logic            mode,
  input  logic [N_IN-1:0] seed,
  output logic [N_IN-1:0] vec,
  output logic            last
);

  localparam int unsigned IDX_W = N_IN + 1;
  localparam logic [IDX_W-1:0] LAST_EXH  = IDX_W'(EXH_VECTORS - 1);
  localparam logic [IDX_W-1:0] LAST_LFSR = IDX_W'(LFSR_VECTORS - 1);
  localparam logic [N_IN-1:0]  ONE       = N_IN'(1);

  logic             run_mode;
  logic [IDX_W-1:0] idx;
  logic [N_IN-1:0]  vec_next;

  always_comb begin
    vec_next = vec + ONE;
    if (run_mode) begin
      vec_next = {vec[N_IN-2:0], vec[LFSR_TAP_HI] ^ vec[LFSR_TAP_LO]};
    end
  end

  // The run length follows the mode latched at load, not the live input.
  assign last = (idx == (run_mode ? LAST_LFSR : LAST_EXH));

  always_ff @(posedge clk) begin
    if (rst) begin
      vec      <= '0;
      idx      <= '0;
      run_mode <= 1'b0;
    end else if (load) begin
      run_mode <= mode;
      idx      <= '0;
      if (!mode) begin
        vec <= '0;
      end else if (seed == '0) begin
        vec <= ONE;
      end else begin
        vec <= seed;
      end
    end else if (clear) begin
      vec <= '0;
      idx <= '0;
    end else if (advance) begin
      vec <= vec_next;
      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/or7_equiv_checker.sv
// ---------------------------------------------------------------------------
// or7_equiv_checker
// Drives a common stimulus vector into two combinational OR7 implementations
// and compares their outputs every cycle of a run, accumulating a saturating
// mismatch count and the first failing vector/bit mask.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a run (honoured in IDLE or DONE)
//   abort             end a run early (honoured in RUN, beats start)
//   mode, seed        stimulus mode and LFSR seed, sampled at start
//   vec_out           vector applied to both DUTs (bit i -> Ii)
//   a_out, b_out      {O1,O0} from variant A and variant B
//   busy, done, pass  run status; pass valid while done
//   mismatch_cnt      saturating count of mismatching vectors
//   first_fail_*      valid flag, vector and a^b mask of the first mismatch
// ---------------------------------------------------------------------------
module or7_equiv_checker
  import or7_chk_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned N_OUT = N_OUT_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [N_IN-1:0]  seed,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] a_out,
  input  logic [N_OUT-1:0] b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic [N_OUT-1:0] first_fail_mask
);

  state_t           state;
  logic             in_run;
  logic             start_run;
  logic             mism;
  logic             last;
  logic             gen_load;
  logic             gen_clear;
  logic             gen_advance;
  logic [CNT_W-1:0] cnt_upd;

  always_comb begin
    in_run      = (state == ST_RUN);
    start_run   = start && ((state == ST_IDLE) || (state == ST_DONE));
    mism        = (a_out != b_out);
    cnt_upd     = mismatch_cnt;
    if (mism && (mismatch_cnt != '1)) begin
      cnt_upd = mismatch_cnt + CNT_W'(1);
    end
    gen_load    = start_run;
    gen_clear   = in_run && (abort || last);
    gen_advance = in_run && !abort && !last;
  end

  or7_vec_gen #(
    .N_IN (N_IN)
  ) u_vec_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (gen_load),
    .clear   (gen_clear),
    .advance (gen_advance),
    .mode    (mode),
    .seed    (seed),
    .vec     (vec_out),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_mask  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state            <= ST_RUN;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_mask  <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            mismatch_cnt <= cnt_upd;
            if (mism && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec_out;
              first_fail_mask  <= a_out ^ b_out;
            end
            // Verdict uses the updated count so the final vector is included.
            if (last) begin
              state <= ST_DONE;
              pass  <= (cnt_upd == '0);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_or7_equiv_checker.sv
// ---------------------------------------------------------------------------
// tb_or7_equiv_checker
// Bench for or7_equiv_checker. Two OR7 variants are modelled here: variant B
// equals variant A with an optional stuck-at-0 on O0 and a per-vector XOR
// fault table. Expected results come from a reference model that lists the
// run's vectors and counts differing outputs directly.
// ---------------------------------------------------------------------------
module tb_or7_equiv_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       mode;
  logic [6:0] seed;
  logic [6:0] vec_out;
  logic [1:0] a_out;
  logic [1:0] b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] mismatch_cnt;
  logic       first_fail_valid;
  logic [6:0] first_fail_vec;
  logic [1:0] first_fail_mask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] fault_tbl [128];
  bit         stuck_o0;

  logic [6:0] exp_vecs[$];
  logic [6:0] obs_vecs[$];
  int         exp_cnt;
  bit         exp_ffv;
  logic [6:0] exp_ffvec;
  logic [1:0] exp_ffmask;
  bit         obs_timeout;

  always #5 clk = ~clk;

  or7_equiv_checker #(
    .N_IN  (7),
    .N_OUT (2),
    .CNT_W (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .mode             (mode),
    .seed             (seed),
    .vec_out          (vec_out),
    .a_out            (a_out),
    .b_out            (b_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .mismatch_cnt     (mismatch_cnt),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec),
    .first_fail_mask  (first_fail_mask)
  );

  // OR7 reference: O0 = OR of all inputs, O1 = OR of I3..I6.
  function automatic logic [1:0] or7_ref(input logic [6:0] v);
    return {|v[6:3], |v};
  endfunction

  function automatic logic [1:0] b_variant(input logic [6:0] v);
    logic [1:0] r;
    r = or7_ref(v);
    if (stuck_o0) r[0] = 1'b0;
    return r ^ fault_tbl[v];
  endfunction

  always_comb begin
    a_out = or7_ref(vec_out);
    b_out = b_variant(vec_out);
  end

  task automatic clear_faults();
    for (int v = 0; v < 128; v++) fault_tbl[v] = 2'b00;
    stuck_o0 = 1'b0;
  endtask

  task automatic random_faults();
    for (int v = 0; v < 128; v++)
      fault_tbl[v] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    stuck_o0 = 1'($urandom_range(0, 3) == 0);
  endtask

  // Reference model: enumerate the run's vectors and tally A/B disagreements.
  task automatic build_model(input bit m, input logic [6:0] s);
    logic [6:0] v;
    logic [1:0] a;
    logic [1:0] b;
    exp_vecs.delete();
    if (!m) begin
      for (int i = 0; i < 128; i++) exp_vecs.push_back(7'(i));
    end else begin
      v = (s == 7'd0) ? 7'd1 : s;
      for (int i = 0; i < 127; i++) begin
        exp_vecs.push_back(v);
        v = {v[5:0], v[6] ^ v[5]};
      end
    end
    exp_cnt    = 0;
    exp_ffv    = 1'b0;
    exp_ffvec  = 7'd0;
    exp_ffmask = 2'b00;
    foreach (exp_vecs[i]) begin
      a = or7_ref(exp_vecs[i]);
      b = b_variant(exp_vecs[i]);
      if (a != b) begin
        if (exp_cnt < 255) exp_cnt++;
        if (!exp_ffv) begin
          exp_ffv    = 1'b1;
          exp_ffvec  = exp_vecs[i];
          exp_ffmask = a ^ b;
        end
      end
    end
  endtask

  // {done, busy, pass, cnt, ffv, ffvec, ffmask, vec_out}
  function automatic logic [27:0] exp_result();
    return {1'b1, 1'b0, (exp_cnt == 0), 8'(exp_cnt), exp_ffv, exp_ffvec, exp_ffmask, 7'd0};
  endfunction

  function automatic logic [27:0] obs_result();
    return {done, busy, pass, mismatch_cnt, first_fail_valid, first_fail_vec,
            first_fail_mask, vec_out};
  endfunction

  function automatic int seq_errs();
    int n;
    int e;
    n = (obs_vecs.size() < exp_vecs.size()) ? obs_vecs.size() : exp_vecs.size();
    e = obs_vecs.size() + exp_vecs.size() - 2 * n;
    for (int i = 0; i < n; i++) if (obs_vecs[i] !== exp_vecs[i]) e++;
    return e;
  endfunction

  // Pulse start, then record vec_out on every busy cycle. mode/seed are
  // scrambled during the run since they must only matter at start.
  task automatic do_run(input bit m, input logic [6:0] s);
    start = 1'b1;
    mode  = m;
    seed  = s;
    @(posedge clk); #1;
    start = 1'b0;
    obs_vecs.delete();
    obs_timeout = 1'b0;
    while (busy) begin
      obs_vecs.push_back(vec_out);
      mode = 1'($urandom);
      seed = 7'($urandom);
      @(posedge clk); #1;
      if (obs_vecs.size() > 200) begin
        obs_timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; seed = 7'd0;
    clear_faults();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (obs_result() !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs_result(), 28'd0);
    end
  endtask

  task automatic test_exhaustive_clean();
    clear_faults();
    build_model(1'b0, 7'd0);
    do_run(1'b0, 7'd0);
    n_checks++;
    if (obs_timeout !== 1'b0) begin
      n_fail++; $display("FAIL clean_timeout: got %0b expected 0", obs_timeout);
    end
    n_checks++;
    if (seq_errs() !== 0) begin
      n_fail++; $display("FAIL clean_seq: %0d vectors observed, %0d differ, expected 128 in order",
                         obs_vecs.size(), seq_errs());
    end
    n_checks++;
    if (obs_result() !== {1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 7'd0, 2'b00, 7'd0}) begin
      n_fail++; $display("FAIL clean_result: got %h expected %h", obs_result(), exp_result());
    end
    // Results must hold in DONE while no start arrives.
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_result() !== exp_result()) begin
      n_fail++; $display("FAIL clean_hold: got %h expected %h", obs_result(), exp_result());
    end
  endtask

  task automatic test_single_fault();
    clear_faults();
    fault_tbl[5] = 2'b10;
    build_model(1'b0, 7'd0);
    do_run(1'b0, 7'd0);
    n_checks++;
    if (seq_errs() !== 0) begin
      n_fail++; $display("FAIL single_seq: %0d differences", seq_errs());
    end
    n_checks++;
    if ({done, pass, mismatch_cnt, first_fail_valid, first_fail_vec, first_fail_mask}
        !== {1'b1, 1'b0, 8'd1, 1'b1, 7'h05, 2'b10}) begin
      n_fail++; $display("FAIL single_result: done=%0b pass=%0b cnt=%0d ffv=%0b vec=%h mask=%b expected 1 0 1 1 05 10",
                         done, pass, mismatch_cnt, first_fail_valid, first_fail_vec, first_fail_mask);
    end
  endtask

  task automatic test_stuck_o0();
    clear_faults();
    stuck_o0 = 1'b1;
    build_model(1'b0, 7'd0);
    do_run(1'b0, 7'd0);
    n_checks++;
    if ({done, pass, mismatch_cnt, first_fail_vec, first_fail_mask}
        !== {1'b1, 1'b0, 8'd127, 7'h01, 2'b01}) begin
      n_fail++; $display("FAIL stuck_result: done=%0b pass=%0b cnt=%0d vec=%h mask=%b expected 1 0 127 01 01",
                         done, pass, mismatch_cnt, first_fail_vec, first_fail_mask);
    end
    n_checks++;
    if (obs_result() !== exp_result()) begin
      n_fail++; $display("FAIL stuck_model: got %h expected %h", obs_result(), exp_result());
    end
  endtask

  task automatic test_lfsr_seed0();
    bit seen [128];
    int distinct;
    clear_faults();
    build_model(1'b1, 7'd0);
    do_run(1'b1, 7'd0);
    n_checks++;
    if (obs_vecs.size() < 4 || {obs_vecs[0], obs_vecs[1], obs_vecs[2], obs_vecs[3]}
        !== {7'h01, 7'h02, 7'h04, 7'h08}) begin
      n_fail++; $display("FAIL lfsr_first4: %0d vectors seen, expected 01 02 04 08 first", obs_vecs.size());
    end
    distinct = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    foreach (obs_vecs[i]) begin
      if (obs_vecs[i] != 7'd0 && !seen[obs_vecs[i]]) distinct++;
      seen[obs_vecs[i]] = 1'b1;
    end
    n_checks++;
    if (distinct !== 127 || obs_vecs.size() !== 127) begin
      n_fail++; $display("FAIL lfsr_distinct: got %0d distinct of %0d, expected 127 of 127",
                         distinct, obs_vecs.size());
    end
    n_checks++;
    if (seq_errs() !== 0 || obs_result() !== exp_result()) begin
      n_fail++; $display("FAIL lfsr_result: seq diffs %0d, got %h expected %h",
                         seq_errs(), obs_result(), exp_result());
    end
  endtask

  task automatic test_random();
    bit         m;
    logic [6:0] s;
    for (int r = 0; r < 5; r++) begin
      random_faults();
      m = 1'($urandom);
      s = (r == 0) ? 7'd0 : 7'($urandom);
      build_model(m, s);
      do_run(m, s);
      n_checks++;
      if (seq_errs() !== 0 || obs_timeout !== 1'b0) begin
        n_fail++; $display("FAIL random_seq[%0d]: mode=%0b seed=%h diffs=%0d timeout=%0b",
                           r, m, s, seq_errs(), obs_timeout);
      end
      n_checks++;
      if (obs_result() !== exp_result()) begin
        n_fail++; $display("FAIL random_result[%0d]: got %h expected %h", r, obs_result(), exp_result());
      end
    end
  endtask

  task automatic test_back_to_back();
    random_faults();
    fault_tbl[7'h40] = 2'b11;
    do_run(1'b0, 7'd0);
    // Restart straight from DONE with a clean pair: old results must be gone.
    clear_faults();
    build_model(1'b1, 7'h5A);
    do_run(1'b1, 7'h5A);
    n_checks++;
    if (seq_errs() !== 0 || obs_result() !== exp_result()) begin
      n_fail++; $display("FAIL b2b_result: diffs=%0d got %h expected %h",
                         seq_errs(), obs_result(), exp_result());
    end
  endtask

  task automatic test_abort_restart();
    clear_faults();
    fault_tbl[3]  = 2'b01;
    fault_tbl[90] = 2'b10;
    start = 1'b1; mode = 1'b0; seed = 7'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if ({busy, vec_out, mismatch_cnt} !== {1'b1, 7'd9, 8'd1}) begin
      n_fail++; $display("FAIL abort_pre: busy=%0b vec=%h cnt=%0d expected 1 09 1", busy, vec_out, mismatch_cnt);
    end
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({busy, done, vec_out} !== {1'b0, 1'b0, 7'd0}) begin
      n_fail++; $display("FAIL abort_idle: busy=%0b done=%0b vec=%h expected 0 0 00", busy, done, vec_out);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    build_model(1'b0, 7'd0);
    do_run(1'b0, 7'd0);
    n_checks++;
    if (seq_errs() !== 0 || obs_result() !== exp_result()) begin
      n_fail++; $display("FAIL abort_restart: diffs=%0d got %h expected %h",
                         seq_errs(), obs_result(), exp_result());
    end
  endtask

  task automatic test_rst_midrun();
    clear_faults();
    fault_tbl[2] = 2'b11;
    start = 1'b1; mode = 1'b0; seed = 7'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({busy, vec_out, mismatch_cnt, first_fail_valid} !== {1'b1, 7'd6, 8'd1, 1'b1}) begin
      n_fail++; $display("FAIL rst_prestate: busy=%0b vec=%h cnt=%0d ffv=%0b expected 1 06 1 1",
                         busy, vec_out, mismatch_cnt, first_fail_valid);
    end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    n_checks++;
    if (obs_result() !== 28'd0) begin
      n_fail++; $display("FAIL rst_midrun: got %h expected %h", obs_result(), 28'd0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs_result() !== 28'd0) begin
      n_fail++; $display("FAIL rst_after: got %h expected %h", obs_result(), 28'd0);
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive_clean();
    test_single_fault();
    test_stuck_o0();
    test_lfsr_seed0();
    test_random();
    test_back_to_back();
    test_abort_restart();
    test_rst_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
